// File: rtl/load_store_unit.sv
// Load/store sequencer: takes one request from execute, strobes the memory
// interface once, then waits for the matching response or a timeout.
module load_store_unit #(
    parameter int TIMEOUT = 15,
    parameter int REG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_load,
    input  logic             ex_store,
    input  logic [12:0]      ex_address,
    input  logic [31:0]      ex_store_data,
    input  logic [1:0]       ex_word_type,
    input  logic             ex_is_signed,
    input  logic [REG_W-1:0] ex_dest_reg,
    output logic [12:0]      mi_address,
    output logic [31:0]      mi_data_in,
    output logic [1:0]       mi_word_type,
    output logic             mi_is_signed,
    output logic             mi_load,
    output logic             mi_store,
    input  logic [31:0]      mi_data_out,
    input  logic             mi_output_valid,
    input  logic             mi_write_ready,
    input  logic             mi_busy,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_dest_reg,
    output logic [31:0]      wb_data,
    output logic             store_done,
    output logic             lsu_fault,
    output logic [1:0]       fault_code,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t             state_q, state_d;
    logic [12:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         wtype_q, wtype_d;
    logic               signed_q, signed_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               is_load_q, is_load_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               mi_load_q, mi_load_d;
    logic               mi_store_q, mi_store_d;
    logic               wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]   wb_dest_q, wb_dest_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               store_done_q, store_done_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic               legal;
    logic [7:0]         cnt_inc;

    // Handshake: a request transfers on any rising edge where ex_valid and
    // ex_ready are both high; ex_ready is high only in IDLE.
    assign ex_ready = (state_q == IDLE);
    assign legal    = (ex_load ^ ex_store) && (ex_word_type != 2'b11);
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wtype_d      = wtype_q;
        signed_d     = signed_q;
        dest_d       = dest_q;
        is_load_d    = is_load_q;
        cnt_d        = cnt_q;
        mi_load_d    = 1'b0;
        mi_store_d   = 1'b0;
        wb_valid_d   = 1'b0;
        wb_dest_d    = wb_dest_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (legal) begin
                        addr_d    = ex_address;
                        data_d    = ex_store_data;
                        wtype_d   = ex_word_type;
                        signed_d  = ex_is_signed;
                        dest_d    = ex_dest_reg;
                        is_load_d = ex_load;
                        // Strobe is registered, so busy is judged at the edge before it shows.
                        mi_load_d  = ex_load & ~mi_busy;
                        mi_store_d = ex_store & ~mi_busy;
                        state_d    = ISSUE;
                    end else begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                    end
                end
            end
            ISSUE: begin
                if (mi_load_q || mi_store_q) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end else if (!mi_busy) begin
                    mi_load_d  = is_load_q;
                    mi_store_d = ~is_load_q;
                end
            end
            WAIT: begin
                if (is_load_q && mi_output_valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = mi_data_out;
                    wb_dest_d  = dest_q;
                    state_d    = IDLE;
                end else if (!is_load_q && mi_write_ready) begin
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TIMEOUT_C) begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            wtype_q      <= '0;
            signed_q     <= 1'b0;
            dest_q       <= '0;
            is_load_q    <= 1'b0;
            cnt_q        <= '0;
            mi_load_q    <= 1'b0;
            mi_store_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wtype_q      <= wtype_d;
            signed_q     <= signed_d;
            dest_q       <= dest_d;
            is_load_q    <= is_load_d;
            cnt_q        <= cnt_d;
            mi_load_q    <= mi_load_d;
            mi_store_q   <= mi_store_d;
            wb_valid_q   <= wb_valid_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign mi_address   = addr_q;
    assign mi_data_in   = data_q;
    assign mi_word_type = wtype_q;
    assign mi_is_signed = signed_q;
    assign mi_load      = mi_load_q;
    assign mi_store     = mi_store_q;
    assign wb_valid     = wb_valid_q;
    assign wb_dest_reg  = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign store_done   = store_done_q;
    assign lsu_fault    = fault_q;
    assign fault_code   = fault_code_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, busy-stalled store, illegal
// requests, timeout boundary, reset mid-WAIT and mismatched responses.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_load;
    logic        ex_store;
    logic [12:0] ex_address;
    logic [31:0] ex_store_data;
    logic [1:0]  ex_word_type;
    logic        ex_is_signed;
    logic [3:0]  ex_dest_reg;
    logic [12:0] mi_address;
    logic [31:0] mi_data_in;
    logic [1:0]  mi_word_type;
    logic        mi_is_signed;
    logic        mi_load;
    logic        mi_store;
    logic [31:0] mi_data_out;
    logic        mi_output_valid;
    logic        mi_write_ready;
    logic        mi_busy;
    logic        wb_valid;
    logic [3:0]  wb_dest_reg;
    logic [31:0] wb_data;
    logic        store_done;
    logic        lsu_fault;
    logic [1:0]  fault_code;
    logic [1:0]  dbg_state;

    int checks;
    int failures;
    int store_pulses;

    load_store_unit #(.TIMEOUT(15), .REG_W(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_load(ex_load), .ex_store(ex_store),
        .ex_address(ex_address), .ex_store_data(ex_store_data),
        .ex_word_type(ex_word_type), .ex_is_signed(ex_is_signed),
        .ex_dest_reg(ex_dest_reg),
        .mi_address(mi_address), .mi_data_in(mi_data_in),
        .mi_word_type(mi_word_type), .mi_is_signed(mi_is_signed),
        .mi_load(mi_load), .mi_store(mi_store),
        .mi_data_out(mi_data_out), .mi_output_valid(mi_output_valid),
        .mi_write_ready(mi_write_ready), .mi_busy(mi_busy),
        .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg), .wb_data(wb_data),
        .store_done(store_done), .lsu_fault(lsu_fault),
        .fault_code(fault_code), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mi_store === 1'b1) store_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_address = '0;
        ex_store_data = '0; ex_word_type = '0; ex_is_signed = 0; ex_dest_reg = '0;
        mi_data_out = '0; mi_output_valid = 0; mi_write_ready = 0; mi_busy = 0;
    endtask

    task automatic req(input logic ld, input logic st, input logic [12:0] a,
                       input logic [31:0] d, input logic [1:0] wt, input logic [3:0] dst);
        ex_valid = 1; ex_load = ld; ex_store = st; ex_address = a;
        ex_store_data = d; ex_word_type = wt; ex_dest_reg = dst;
    endtask

    initial begin
        checks = 0; failures = 0; store_pulses = 0;
        idle_inputs();
        reset = 0;
        step(); step();
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_state", dbg_state, 0);
        chk("rst_strobes", {mi_load, mi_store, wb_valid, store_done, lsu_fault}, 0);
        chk("rst_fault_code", fault_code, 0);
        chk("rst_buses", {mi_address, mi_word_type, wb_dest_reg}, 0);
        reset = 1;
        step();

        // Load word at 0x014, dest 3, response 3 cycles into WAIT
        req(1, 0, 13'h014, 0, 2'b10, 4'd3);
        step();
        idle_inputs();
        chk("ld_strobe", mi_load, 1);
        chk("ld_addr", mi_address, 13'h014);
        chk("ld_not_ready", ex_ready, 0);
        step();
        chk("ld_strobe_width", mi_load, 0);
        step(); step();
        mi_output_valid = 1; mi_data_out = 32'hDEADBEEF;
        step();
        idle_inputs();
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_dest", wb_dest_reg, 3);
        chk("ld_ready_after", ex_ready, 1);
        step();
        chk("ld_wb_pulse_width", wb_valid, 0);

        // write_ready during a pending load is ignored
        req(1, 0, 13'h020, 0, 2'b00, 4'd5);
        step();
        idle_inputs();
        step();
        mi_write_ready = 1;
        step();
        mi_write_ready = 0;
        chk("wr_ign_wb", wb_valid, 0);
        chk("wr_ign_busy", ex_ready, 0);
        chk("wr_ign_done", store_done, 0);
        mi_output_valid = 1; mi_data_out = 32'h000000A5;
        step();
        idle_inputs();
        chk("wr_ign_wb_valid", wb_valid, 1);
        chk("wr_ign_data", wb_data, 32'h000000A5);
        chk("wr_ign_dest", wb_dest_reg, 5);

        // Half-word store stalled by mi_busy for 4 cycles
        store_pulses = 0;
        mi_busy = 1;
        req(0, 1, 13'h003, 32'h1234, 2'b01, 4'd0);
        step();
        ex_valid = 0; ex_store = 0;
        chk("st_busy_strobe0", mi_store, 0);
        chk("st_addr", mi_address, 13'h003);
        chk("st_data", mi_data_in, 32'h1234);
        chk("st_wtype", mi_word_type, 2'b01);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("st_busy_strobe", mi_store, 0);
        end
        mi_busy = 0;
        step();
        chk("st_strobe", mi_store, 1);
        step();
        chk("st_strobe_width", mi_store, 0);
        mi_write_ready = 1;
        step();
        mi_write_ready = 0;
        chk("st_done", store_done, 1);
        chk("st_ready", ex_ready, 1);
        step();
        chk("st_done_width", store_done, 0);
        chk("st_single_pulse", store_pulses, 1);

        // Illegal: both ops, then word type 11
        req(1, 1, 13'h100, 0, 2'b10, 4'd1);
        step();
        ex_valid = 0;
        chk("ill_both_fault", lsu_fault, 1);
        chk("ill_both_code", fault_code, 2'b01);
        chk("ill_both_ready", ex_ready, 1);
        chk("ill_both_nostrobe", {mi_load, mi_store}, 0);
        chk("ill_addr_kept", mi_address, 13'h003);
        step();
        chk("ill_fault_width", lsu_fault, 0);
        chk("ill_code_hold", fault_code, 2'b01);
        req(1, 0, 13'h100, 0, 2'b11, 4'd1);
        step();
        idle_inputs();
        chk("ill_wt_fault", lsu_fault, 1);
        chk("ill_wt_code", fault_code, 2'b01);
        chk("ill_wt_nostrobe", {mi_load, mi_store}, 0);
        step();

        // Timeout: no response for 15 WAIT edges
        req(1, 0, 13'h040, 0, 2'b10, 4'd7);
        step();
        idle_inputs();
        step();
        for (int i = 1; i < 15; i++) begin
            step();
            chk("to_no_fault_yet", lsu_fault, 0);
        end
        step();
        chk("to_fault", lsu_fault, 1);
        chk("to_code", fault_code, 2'b10);
        chk("to_ready", ex_ready, 1);
        chk("to_no_wb", wb_valid, 0);
        step();

        // Response on the timeout edge wins
        req(1, 0, 13'h044, 0, 2'b10, 4'd9);
        step();
        idle_inputs();
        step();
        for (int i = 1; i < 15; i++) step();
        mi_output_valid = 1; mi_data_out = 32'hCAFE0001;
        step();
        idle_inputs();
        chk("race_wb", wb_valid, 1);
        chk("race_no_fault", lsu_fault, 0);
        chk("race_data", wb_data, 32'hCAFE0001);
        step();

        // Reset mid-WAIT, then a late response
        req(1, 0, 13'h0AA, 0, 2'b10, 4'd2);
        step();
        idle_inputs();
        step(); step();
        reset = 0;
        #1;
        chk("mid_rst_ready", ex_ready, 1);
        chk("mid_rst_bus", {mi_address, mi_word_type, wb_dest_reg}, 0);
        chk("mid_rst_data", wb_data, 0);
        chk("mid_rst_code", fault_code, 0);
        step();
        reset = 1;
        mi_output_valid = 1; mi_data_out = 32'h11111111;
        step();
        chk("late_rsp_wb", wb_valid, 0);
        step();
        idle_inputs();
        chk("late_rsp_wb2", wb_valid, 0);
        chk("late_rsp_ready", ex_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the execute stage and `memory_interface_v3`. It accepts one load or store request at a time from execute and presents it to the memory interface with a single-cycle strobe, holding address, data and type stable. It then waits for `output_valid` (loads) or `write_ready` (stores), returns load data to writeback, and flags illegal requests and memory timeouts.

## Interface
- `TIMEOUT`, 15: maximum number of WAIT cycles before a fault is raised; legal range 2..255.
- `REG_W`, 4: width of the destination register index.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents a request.
- `ex_ready`  out  1  unit can accept a request; high only in IDLE.
- `ex_load`, `ex_store`  in  1 each  operation select; exactly one must be high.
- `ex_address`  in  13  byte address; bit 0 is the half-word offset.
- `ex_store_data`  in  32  store data.
- `ex_word_type`  in  2  `00` byte, `01` half-word, `10` word; `11` is illegal.
- `ex_is_signed`  in  1  sign-extend the load result.
- `ex_dest_reg`  in  REG_W  destination register for the load.
- `mi_address`  out  13  held request address.
- `mi_data_in`  out  32  held store data.
- `mi_word_type`  out  2  held word type.
- `mi_is_signed`  out  1  held signedness.
- `mi_load`, `mi_store`  out  1 each  one-cycle strobes.
- `mi_data_out`  in  32  load data from the memory interface.
- `mi_output_valid`  in  1  load data valid.
- `mi_write_ready`  in  1  store complete.
- `mi_busy`  in  1  memory interface cannot accept a strobe.
- `wb_valid`  out  1  one-cycle pulse: load result available.
- `wb_dest_reg`  out  REG_W  register index for the load result.
- `wb_data`  out  32  load result.
- `store_done`  out  1  one-cycle pulse: store completed.
- `lsu_fault`  out  1  one-cycle pulse: illegal request or timeout.
- `fault_code`  out  2  `01` illegal, `10` timeout; holds its value until the next fault.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - `ex_ready`=1.
  - On `ex_valid` with a legal request: latch address, store data, word type, is_signed, dest_reg and operation into request registers; go to ISSUE.
  - Legal means exactly one of `ex_load`/`ex_store` is high and `ex_word_type`≠`11`.
  - On an illegal request: consume it (no memory access), pulse `lsu_fault` with `fault_code`=`01`, stay in IDLE.
- **ISSUE**
  - If `mi_busy`=1: strobes stay low, remain in ISSUE. No timeout applies in ISSUE.
  - If `mi_busy`=0: assert `mi_load` or `mi_store` for exactly this cycle, clear the timeout counter, go to WAIT.
- **WAIT**
  - Timeout counter increments every cycle.
  - Load: `mi_output_valid`=1 → capture `mi_data_out` into `wb_data` unmodified; go to IDLE.
  - Store: `mi_write_ready`=1 → go to IDLE.
  - The response that does not match the pending operation is ignored.
  - Counter reaches `TIMEOUT` with no response → pulse `lsu_fault` with `fault_code`=`10`; go to IDLE; no wb/store_done pulse.
- `mi_address`, `mi_data_in`, `mi_word_type` and `mi_is_signed` are driven from the request registers. They stay stable from ISSUE entry until the request registers are next loaded.
- `mi_output_valid` and `mi_write_ready` are ignored in IDLE and ISSUE.
- Counter width: 8 bits. It saturates; it does not wrap.

## Timing
- Reset asserted (async, active-low):
  - State → IDLE.
  - `ex_ready`=1; `mi_load`, `mi_store`, `wb_valid`, `store_done`, `lsu_fault`=0.
  - `fault_code`=`00`; `wb_data`, `wb_dest_reg`, `mi_*` buses = 0.
  - Any in-flight operation is abandoned; a late response after reset is ignored.
- Accept edge N → ISSUE in N+1.
  - With `mi_busy`=0, the strobe is high during cycle N+1 and WAIT starts at N+2.
- A response sampled at edge M gives `wb_valid`/`store_done` high during cycle M+1 with state IDLE. The next request can be accepted at edge M+1.
- Minimum spacing between accepts: 3 cycles.
- Timeout: with no response, `lsu_fault` is high in the cycle after the `TIMEOUT`-th WAIT edge.
- A response arriving on the same edge as the timeout wins: normal completion, no fault.
- All outputs are registered except `ex_ready`, which is decoded from state.

## Test plan
- Reset released, then `ex_load`, `ex_address`=`0x014`, word type `10`, dest 3.
  - Required: `mi_load` is a 1-cycle pulse with `mi_address`=`0x014`.
  - Drive `mi_output_valid` 3 cycles later with data `0xDEADBEEF` → `wb_valid` pulse, `wb_data`=`0xDEADBEEF`, `wb_dest_reg`=3.
- Store of half-word `0x1234` at `0x003` while `mi_busy`=1 for 4 cycles.
  - Required: no strobe while busy; a single `mi_store` pulse after busy falls; `store_done` 1 cycle after `mi_write_ready`.
- `ex_load`=`ex_store`=1, then separately word type `11`.
  - Required: each consumed in 1 cycle, `lsu_fault` pulse with `fault_code`=`01`, no `mi_*` strobe.
- Load with no response, `TIMEOUT`=15.
  - Required: `lsu_fault` with `fault_code`=`10` after 15 WAIT cycles, no `wb_valid`, `ex_ready` high the same cycle.
- Reset asserted mid-WAIT, then `mi_output_valid` after reset is released.
  - Required: all outputs return to their reset values immediately, and no `wb_valid` is produced.
- `mi_write_ready` pulsed during a pending load.
  - Required: ignored; only `mi_output_valid` completes the load.
